// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_stage
// Purpose  : Pipelined RV32I decode stage. Accepts fetched instructions on a
//            valid/ready handshake, decodes them combinationally and registers
//            the result into a main output register. A second (skid) entry
//            keeps full throughput while in_ready stays a registered signal.
//            flush empties the stage and drops any incoming instruction.
// Ports    : clk, rst_n (async active-low)
//            in_valid / in_ready / in_instr[31:0] / in_pc[WIDTH-1:0]
//            flush
//            out_valid / out_ready / out_pc
//            rs1_addr, rs2_addr, rd_addr, funct3, funct7, imm[WIDTH-1:0]
//            isALUreg, isALUimm, isBranch, isJAL, isJALR, isLUI, isAUIPC,
//            isLoad, isStore, isSystem, illegal
// Config   : DECODE_ILLEGAL_CHECK_EN - when defined, illegal encodings are
//            flagged and their is* flags forced to 0; otherwise illegal = 0.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic [4:0]       rd_addr,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [WIDTH-1:0] imm,
  output logic             isALUreg,
  output logic             isALUimm,
  output logic             isBranch,
  output logic             isJAL,
  output logic             isJALR,
  output logic             isLUI,
  output logic             isAUIPC,
  output logic             isLoad,
  output logic             isStore,
  output logic             isSystem,
  output logic             illegal
);

  localparam logic [6:0] C_OP_ALUREG = 7'b0110011;
  localparam logic [6:0] C_OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

  // Flag vector order: ALUreg, ALUimm, Branch, JAL, JALR, LUI, AUIPC, Load, Store, System
  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [WIDTH-1:0] imm;
    logic [9:0]       flags;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_out_valid;
  logic   r_in_ready;
  entry_t r_main;
  entry_t r_skid;
  entry_t w_dec;

  logic        w_accept;
  logic        w_pop;
  logic        w_load_main_new;
  logic        w_load_main_skid;
  logic        w_load_skid;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [9:0]  w_kind;
  logic [31:0] w_imm32;
  logic        w_bad;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // --------------------------------------------------------------------------
  always_comb begin
    w_kind  = 10'd0;
    w_imm32 = 32'd0;
    case (w_opcode)
      C_OP_ALUREG: w_kind = 10'b10_0000_0000;
      C_OP_ALUIMM: begin
        w_kind  = 10'b01_0000_0000;
        w_imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
      end
      C_OP_BRANCH: begin
        w_kind  = 10'b00_1000_0000;
        w_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      C_OP_JAL: begin
        w_kind  = 10'b00_0100_0000;
        w_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      C_OP_JALR: begin
        w_kind  = 10'b00_0010_0000;
        w_imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
      end
      C_OP_LUI: begin
        w_kind  = 10'b00_0001_0000;
        w_imm32 = {in_instr[31:12], 12'b0};
      end
      C_OP_AUIPC: begin
        w_kind  = 10'b00_0000_1000;
        w_imm32 = {in_instr[31:12], 12'b0};
      end
      C_OP_LOAD: begin
        w_kind  = 10'b00_0000_0100;
        w_imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
      end
      C_OP_STORE: begin
        w_kind  = 10'b00_0000_0010;
        w_imm32 = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
      end
      C_OP_SYSTEM: begin
        w_kind  = 10'b00_0000_0001;
        w_imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
      end
      default: begin
        w_kind  = 10'd0;
        w_imm32 = 32'd0;
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  always_comb begin
    w_bad = 1'b0;
    case (w_opcode)
      C_OP_ALUREG: w_bad = ((w_f7 != 7'h00) && (w_f7 != 7'h20)) ||
                           ((w_f7 == 7'h20) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
      // Shift-immediates reuse funct7 as a sub-opcode; only srai may set 0x20
      C_OP_ALUIMM: begin
        if (w_f3 == 3'b001)
          w_bad = (w_f7 != 7'h00);
        else if (w_f3 == 3'b101)
          w_bad = (w_f7 != 7'h00) && (w_f7 != 7'h20);
        else
          w_bad = 1'b0;
      end
      C_OP_BRANCH: w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      C_OP_LOAD:   w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      C_OP_STORE:  w_bad = (w_f3 >= 3'b011);
      C_OP_JALR:   w_bad = (w_f3 != 3'b000);
      C_OP_JAL, C_OP_LUI, C_OP_AUIPC, C_OP_SYSTEM: w_bad = 1'b0;
      default:     w_bad = 1'b1;
    endcase
    // All known opcodes end in 2'b11, so this is already covered above; kept explicit.
    if (in_instr[1:0] != 2'b11)
      w_bad = 1'b1;
  end
`else
  always_comb begin
    w_bad = 1'b0;
  end
`endif

  always_comb begin
    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.rs1     = in_instr[19:15];
    w_dec.rs2     = in_instr[24:20];
    w_dec.rd      = in_instr[11:7];
    w_dec.f3      = w_f3;
    w_dec.f7      = w_f7;
    w_dec.imm     = WIDTH'($signed(w_imm32));
    w_dec.flags   = w_kind & {10{~w_bad}};
    w_dec.illegal = w_bad;
  end

  // --------------------------------------------------------------------------
  // Occupancy FSM: EMPTY / ONE (main) / TWO (main + skid)
  // --------------------------------------------------------------------------
  assign w_accept = in_valid & r_in_ready & ~flush;
  assign w_pop    = r_out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_new  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next    = ST_ONE;
            w_load_main_new = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            w_load_main_new = 1'b1;
          end else if (w_pop) begin
            w_state_next = ST_EMPTY;
          end else if (w_accept) begin
            w_state_next = ST_TWO;
            w_load_skid  = 1'b1;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_next     = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered copies of the next-state occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next != ST_EMPTY);
      r_in_ready  <= (w_state_next != ST_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_new)
        r_main <= w_dec;
      else if (w_load_main_skid)
        r_main <= r_skid;
      if (w_load_skid)
        r_skid <= w_dec;
    end
  end

  assign out_valid = r_out_valid;
  assign in_ready  = r_in_ready;
  assign out_pc    = r_main.pc;
  assign rs1_addr  = r_main.rs1;
  assign rs2_addr  = r_main.rs2;
  assign rd_addr   = r_main.rd;
  assign funct3    = r_main.f3;
  assign funct7    = r_main.f7;
  assign imm       = r_main.imm;
  assign {isALUreg, isALUimm, isBranch, isJAL, isJALR,
          isLUI, isAUIPC, isLoad, isStore, isSystem} = r_main.flags;
  assign illegal   = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode_stage
// Purpose  : Self-checking bench for instr_decode_stage: directed scenarios
//            plus a randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decode_stage;

  localparam int WIDTH = 32;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  // Index order matches the flag vector: ALUreg..System
  localparam logic [6:0] OPS [10] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                                      7'b1100111, 7'b0110111, 7'b0010111, 7'b0000011,
                                      7'b0100011, 7'b1110011};

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [9:0]  flags;
    logic        illegal;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [4:0]       rs1_addr, rs2_addr, rd_addr;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [WIDTH-1:0] imm;
  logic isALUreg, isALUimm, isBranch, isJAL, isJALR, isLUI, isAUIPC, isLoad, isStore, isSystem;
  logic illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .isALUreg(isALUreg), .isALUimm(isALUimm), .isBranch(isBranch), .isJAL(isJAL),
    .isJALR(isJALR), .isLUI(isLUI), .isAUIPC(isAUIPC), .isLoad(isLoad),
    .isStore(isStore), .isSystem(isSystem), .illegal(illegal)
  );

  // Reference decode built from the ISA rules with integer arithmetic
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int k, s, v;
    logic [2:0] f3;
    logic [6:0] f7;
    bit bad;
    f3  = ins[14:12];
    f7  = ins[31:25];
    s   = int'(ins);
    k   = -1;
    v   = 0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++)
      if (ins[6:0] == OPS[i]) k = i;
    case (k)
      1, 4, 7, 9: v = s >>> 20;
      8:    v = ((s >>> 25) <<< 5) | int'(ins[11:7]);
      2:    v = ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
      5, 6: v = s & 32'hFFFF_F000;
      3:    v = ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
      default: v = 0;
    endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
    case (k)
      -1: bad = 1'b1;
      0:  bad = !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      1:  bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      2:  bad = f3 inside {3'd2, 3'd3};
      4:  bad = f3 != 3'd0;
      7:  bad = f3 inside {3'd3, 3'd6, 3'd7};
      8:  bad = f3 >= 3'd3;
      default: bad = 1'b0;
    endcase
`endif
    e.pc      = pc;
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.rd      = ins[11:7];
    e.f3      = f3;
    e.f7      = f7;
    e.imm     = v;
    e.flags   = (k >= 0 && !bad) ? (10'b1 << (9 - k)) : 10'b0;
    e.illegal = bad;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t a;
    a = {out_pc, rs1_addr, rs2_addr, rd_addr, funct3, funct7, imm,
         isALUreg, isALUimm, isBranch, isJAL, isJALR, isLUI, isAUIPC,
         isLoad, isStore, isSystem, illegal};
    return a;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    r[6:0] = OPS[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one instruction for a single cycle with out_ready high
  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, in_ready, imm, out_pc, observed().flags, illegal} !== {1'b0, 1'b1, 32'd0, 32'd0, 10'd0, 1'b0})
      $display("FAIL reset_state: got v=%b r=%b imm=%h pc=%h flags=%b ill=%b want v=0 r=1 rest 0",
               out_valid, in_ready, imm, out_pc, observed().flags, illegal);
    if ({out_valid, in_ready, imm, out_pc, observed().flags, illegal} !== {1'b0, 1'b1, 32'd0, 32'd0, 10'd0, 1'b0}) fails++;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL pre_reset_valid: got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, in_ready, imm, out_pc} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b r=%b imm=%h pc=%h want v=0 r=1 imm=0 pc=0",
               out_valid, in_ready, imm, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    push_one(32'h0050_0093, 32'h100);   // addi x1,x0,5
    tests++;
    if ({out_valid, isALUimm, rd_addr, rs1_addr, imm, out_pc} !== {1'b1, 1'b1, 5'd1, 5'd0, 32'd5, 32'h100}) begin
      fails++;
      $display("FAIL addi: got v=%b alui=%b rd=%0d rs1=%0d imm=%h pc=%h want 1 1 1 0 00000005 00000100",
               out_valid, isALUimm, rd_addr, rs1_addr, imm, out_pc);
    end
    push_one(32'h4020_81B3, 32'h104);   // sub x3,x1,x2
    tests++;
    if ({isALUreg, funct3, funct7, rs1_addr, rs2_addr, rd_addr, imm} !== {1'b1, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0}) begin
      fails++;
      $display("FAIL sub: got alur=%b f3=%0d f7=%h rs1=%0d rs2=%0d rd=%0d imm=%h want 1 0 20 1 2 3 00000000",
               isALUreg, funct3, funct7, rs1_addr, rs2_addr, rd_addr, imm);
    end
    push_one(32'hFE20_8EE3, 32'h108);   // beq x1,x2,-4
    tests++;
    if ({isBranch, isALUreg, imm} !== {1'b1, 1'b0, 32'hFFFF_FFFC}) begin
      fails++;
      $display("FAIL beq: got br=%b alur=%b imm=%h want 1 0 fffffffc", isBranch, isALUreg, imm);
    end
    @(posedge clk); @(negedge clk);     // drain
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0050_0093; in_pc = 32'h200;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_pc} !== {1'b1, 1'b1, 32'h200}) begin
      fails++; $display("FAIL b2b_first: got r=%b v=%b pc=%h want 1 1 00000200", in_ready, out_valid, out_pc);
    end
    in_instr = 32'h4020_81B3; in_pc = 32'h204;
    @(posedge clk); @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_ready_fall: got %b want 0", in_ready);
    end
    in_instr = 32'hFE20_8EE3; in_pc = 32'h208;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_pc, rd_addr} !== {1'b0, 1'b1, 32'h200, 5'd1}) begin
      fails++; $display("FAIL b2b_hold: got r=%b v=%b pc=%h rd=%0d want 0 1 00000200 1",
                        in_ready, out_valid, out_pc, rd_addr);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    tests++;
    if ({out_valid, out_pc, rd_addr, in_ready} !== {1'b1, 32'h204, 5'd3, 1'b1}) begin
      fails++; $display("FAIL b2b_second: got v=%b pc=%h rd=%0d r=%b want 1 00000204 3 1",
                        out_valid, out_pc, rd_addr, in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if ({out_valid, out_pc, isBranch} !== {1'b1, 32'h208, 1'b1}) begin
      fails++; $display("FAIL b2b_third: got v=%b pc=%h br=%b want 1 00000208 1", out_valid, out_pc, isBranch);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h0050_0093; in_pc = 32'h300;
    @(posedge clk); @(negedge clk);
    in_instr = 32'h4020_81B3; in_pc = 32'h304;
    @(posedge clk); @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_setup_two: got r=%b want 0", in_ready);
    end
    flush = 1'b1; in_instr = 32'hFE20_8EE3; in_pc = 32'h308;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL flush_empty: got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL flush_no_capture: got v=%b want 0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    push_one(32'h0000_0000, 32'h400);
    tests++;
    if ({out_valid, illegal, observed().flags} !== {1'b1, ILL_EN, 10'd0}) begin
      fails++; $display("FAIL illegal_zero: got v=%b ill=%b flags=%b want 1 %b 0000000000",
                        out_valid, illegal, observed().flags, ILL_EN);
    end
    push_one(32'h8020_81B3, 32'h404);   // ALUreg with funct7=0x40
    tests++;
    if ({illegal, isALUreg} !== {ILL_EN, ~ILL_EN}) begin
      fails++; $display("FAIL illegal_funct7: got ill=%b alur=%b want %b %b", illegal, isALUreg, ILL_EN, ~ILL_EN);
    end
    push_one(32'h4020_81B3, 32'h408);
    tests++;
    if ({illegal, isALUreg} !== 2'b01) begin
      fails++; $display("FAIL legal_sub: got ill=%b alur=%b want 0 1", illegal, isALUreg);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random(input int n);
    exp_t q[$];
    exp_t act;
    bit acc, pop;
    do_reset();
    for (int c = 0; c < n; c++) begin
      tests++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        fails++;
        $display("FAIL rand_handshake cyc %0d: got v=%b r=%b want v=%b r=%b",
                 c, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        act = observed();
        tests++;
        if (act !== q[0]) begin
          fails++;
          $display("FAIL rand_entry cyc %0d: got %h want %h", c, act, q[0]);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        pop = (q.size() > 0) && out_ready;
        acc = in_valid && (q.size() < 2);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(model_decode(in_instr, in_pc));
      end
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = '0;
    @(negedge clk);
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
